// File: rtl/shiftreg_sequencer.sv
// Serial shift-register chain driver: shifts a word out on sdo with a divided
// sclk while capturing sdi, then strobes load and reports the captured word.
module shiftreg_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sdi,
    output logic                  sclk,
    output logic                  sdo,
    output logic                  load,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned MAX_DIV = CNT_WIDTH - 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                state_r;
    logic [DIV_WIDTH-1:0]  div_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [IDX_WIDTH-1:0]  idx_r;
    logic [DATA_WIDTH-1:0] tx_r;
    logic [DATA_WIDTH-1:0] rx_r;

    logic [CNT_WIDTH-1:0]  half_max_s;
    logic                  half_end_s;
    logic [DATA_WIDTH-1:0] tx_next_s;

    // Each phase lasts 2**div_r cycles; the clamp on div_r keeps this in range.
    assign half_max_s = (CNT_ONE << div_r) - CNT_ONE;
    assign half_end_s = (cnt_r == half_max_s);
    assign tx_next_s  = tx_r << 1;

    // Sequencer state, phase timing, shift registers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= IDLE;
            div_r   <= '0;
            cnt_r   <= '0;
            idx_r   <= '0;
            tx_r    <= '0;
            rx_r    <= '0;
            sclk    <= 1'b0;
            sdo     <= 1'b0;
            load    <= 1'b0;
            dout    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (32'(div) > MAX_DIV) begin
                            div_r <= DIV_WIDTH'(MAX_DIV);
                        end else begin
                            div_r <= div;
                        end
                        tx_r    <= din;
                        rx_r    <= '0;
                        cnt_r   <= '0;
                        idx_r   <= '0;
                        sclk    <= 1'b0;
                        sdo     <= din[DATA_WIDTH-1];
                        load    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (half_end_s) begin
                        cnt_r   <= '0;
                        sclk    <= 1'b1;
                        // Capture sdi on the sclk rising edge.
                        rx_r    <= DATA_WIDTH'({rx_r, sdi});
                        state_r <= SHIFT_HI;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                SHIFT_HI: begin
                    if (half_end_s) begin
                        cnt_r <= '0;
                        sclk  <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            sdo     <= 1'b0;
                            load    <= 1'b1;
                            state_r <= LOAD;
                        end else begin
                            tx_r    <= tx_next_s;
                            sdo     <= tx_next_s[DATA_WIDTH-1];
                            idx_r   <= idx_r + IDX_WIDTH'(1);
                            state_r <= SHIFT_LO;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                LOAD: begin
                    if (half_end_s) begin
                        cnt_r   <= '0;
                        load    <= 1'b0;
                        dout    <= rx_r;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    sclk    <= 1'b0;
                    sdo     <= 1'b0;
                    load    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Directed self-checking bench for shiftreg_sequencer (8-bit word, 4-bit counter).
module tb_shiftreg_sequencer;

    localparam int DW  = 8;
    localparam int DVW = 4;
    localparam int CW  = 4;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          start;
    logic [DVW-1:0] div;
    logic [DW-1:0] din;
    logic          sdi;
    logic          sdi_val;
    logic          loop_en;
    logic          sclk;
    logic          sdo;
    logic          load;
    logic [DW-1:0] dout;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    // Results of the most recent measured transaction
    int            m_done_cycle;
    int            m_rises;
    int            m_gap_min, m_gap_max;
    int            m_hi_min, m_hi_max;
    int            m_load;
    int            m_busy;
    int            m_pulses;
    logic [DW-1:0] m_bits;
    logic [DW-1:0] m_dout;
    logic          m_timeout;
    logic          m_dout_early;
    logic          m_busy_after;

    shiftreg_sequencer #(
        .DATA_WIDTH(DW),
        .DIV_WIDTH (DVW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .div   (div),
        .start (start),
        .din   (din),
        .sdi   (sdi),
        .sclk  (sclk),
        .sdo   (sdo),
        .load  (load),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    assign sdi = loop_en ? sdo : sdi_val;

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Pulses start, then records timing of sclk/load/busy/done until one cycle past done.
    task automatic measure(input logic [DW-1:0] d, input logic [DVW-1:0] dv,
                           input int chg_at, input logic [DW-1:0] chg_d,
                           input logic [DVW-1:0] chg_dv);
        int       last_rise;
        int       hi_run;
        logic     prev_sclk;
        logic     finished;
        logic [DW-1:0] dout0;
        m_done_cycle = -1; m_rises = 0; m_gap_min = 100000; m_gap_max = 0;
        m_hi_min = 100000; m_hi_max = 0; m_load = 0; m_busy = 0; m_pulses = 0;
        m_bits = '0; m_dout = '0; m_timeout = 1'b0; m_dout_early = 1'b0;
        m_busy_after = 1'b1;
        dout0 = dout;
        din = d; div = dv; start = 1'b1;
        step();
        start = 1'b0;
        prev_sclk = 1'b0; hi_run = 0; last_rise = 0; finished = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k > 0) step();
            if (k == chg_at) begin
                din = chg_d;
                div = chg_dv;
            end
            if (m_done_cycle >= 0 && k == m_done_cycle + 1) begin
                m_busy_after = busy;
                finished = 1'b1;
                break;
            end
            if (sclk && !prev_sclk) begin
                m_rises++;
                if (m_rises > 1) begin
                    if (k - last_rise < m_gap_min) m_gap_min = k - last_rise;
                    if (k - last_rise > m_gap_max) m_gap_max = k - last_rise;
                end
                last_rise = k;
                m_bits = {m_bits[DW-2:0], sdo};
            end
            if (sclk) begin
                hi_run++;
            end else if (prev_sclk) begin
                if (hi_run < m_hi_min) m_hi_min = hi_run;
                if (hi_run > m_hi_max) m_hi_max = hi_run;
                hi_run = 0;
            end
            if (load) m_load++;
            if (busy) m_busy++;
            if (done) begin
                m_pulses++;
                if (m_done_cycle < 0) begin
                    m_done_cycle = k;
                    m_dout = dout;
                end
            end else if (m_done_cycle < 0 && dout !== dout0) begin
                m_dout_early = 1'b1;
            end
            prev_sclk = sclk;
        end
        if (!finished) m_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; din = '0; div = '0;
        step();
        step();
        tests++;
        if ({sclk, sdo, load, busy, done} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_outputs: got %b, want 00000", {sclk, sdo, load, busy, done});
        end
        tests++;
        if (dout !== 8'h00) begin
            fails++;
            $display("FAIL reset_dout: got %h, want 00", dout);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        loop_en = 1'b1;
        measure(8'hA5, 4'd0, -1, 8'h00, 4'd0);
        tests++;
        if (m_timeout !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b, want 0", m_timeout); end
        tests++;
        if (m_done_cycle != 17) begin fails++; $display("FAIL basic_done_cycle: got %0d, want 17", m_done_cycle); end
        tests++;
        if (m_rises != 8) begin fails++; $display("FAIL basic_sclk_rises: got %0d, want 8", m_rises); end
        tests++;
        if (m_gap_min != 2 || m_gap_max != 2) begin fails++; $display("FAIL basic_sclk_period: got %0d..%0d, want 2", m_gap_min, m_gap_max); end
        tests++;
        if (m_load != 1) begin fails++; $display("FAIL basic_load_len: got %0d, want 1", m_load); end
        tests++;
        if (m_dout !== 8'hA5) begin fails++; $display("FAIL basic_dout: got %h, want a5", m_dout); end
        tests++;
        if (m_bits !== 8'hA5) begin fails++; $display("FAIL basic_sdo_bits: got %h, want a5", m_bits); end
        tests++;
        if (m_busy != 18 || m_busy_after !== 1'b0) begin fails++; $display("FAIL basic_busy: got %0d cycles after=%b, want 18 after=0", m_busy, m_busy_after); end
        tests++;
        if (m_pulses != 1) begin fails++; $display("FAIL basic_done_width: got %0d, want 1", m_pulses); end
        tests++;
        if (m_dout_early !== 1'b0) begin fails++; $display("FAIL basic_dout_stable: got %b, want 0", m_dout_early); end
    endtask

    task automatic test_div2();
        loop_en = 1'b0; sdi_val = 1'b1;
        measure(8'h3C, 4'd2, -1, 8'h00, 4'd0);
        tests++;
        if (m_done_cycle != 68) begin fails++; $display("FAIL div2_done_cycle: got %0d, want 68", m_done_cycle); end
        tests++;
        if (m_hi_min != 4 || m_hi_max != 4) begin fails++; $display("FAIL div2_sclk_high: got %0d..%0d, want 4", m_hi_min, m_hi_max); end
        tests++;
        if (m_gap_min != 8 || m_gap_max != 8) begin fails++; $display("FAIL div2_sclk_period: got %0d..%0d, want 8", m_gap_min, m_gap_max); end
        tests++;
        if (m_load != 4) begin fails++; $display("FAIL div2_load_len: got %0d, want 4", m_load); end
        tests++;
        if (m_dout !== 8'hFF) begin fails++; $display("FAIL div2_dout: got %h, want ff", m_dout); end
        tests++;
        if (m_bits !== 8'h3C) begin fails++; $display("FAIL div2_sdo_bits: got %h, want 3c", m_bits); end
        loop_en = 1'b1;
    endtask

    task automatic test_back_to_back();
        int d1, d2, idle, guard;
        d1 = -1; d2 = -1; idle = 0;
        loop_en = 1'b1; din = 8'h5A; div = 4'd0; start = 1'b1;
        step();
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) step();
            if (k == 40) start = 1'b0;
            if (d1 >= 0 && d2 < 0 && !busy) idle++;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) begin
                    d2 = k;
                    tests++;
                    if (dout !== 8'h5A) begin fails++; $display("FAIL b2b_dout: got %h, want 5a", dout); end
                end
            end
        end
        tests++;
        if (d1 != 17 || d2 != 36) begin fails++; $display("FAIL b2b_done_cycles: got %0d,%0d, want 17,36", d1, d2); end
        tests++;
        if (idle != 1) begin fails++; $display("FAIL b2b_idle_gap: got %0d, want 1", idle); end
        guard = 0;
        while (busy && guard < 200) begin step(); guard++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL b2b_return_idle: got busy=%b, want 0", busy); end
    endtask

    task automatic test_din_div_change();
        loop_en = 1'b1;
        measure(8'h96, 4'd0, 3, 8'h00, 4'd3);
        tests++;
        if (m_done_cycle != 17 || m_gap_max != 2) begin fails++; $display("FAIL latch_timing: got done=%0d period=%0d, want 17 and 2", m_done_cycle, m_gap_max); end
        tests++;
        if (m_bits !== 8'h96 || m_dout !== 8'h96) begin fails++; $display("FAIL latch_data: got sdo=%h dout=%h, want 96", m_bits, m_dout); end
    endtask

    task automatic test_clamp();
        loop_en = 1'b1;
        measure(8'h81, 4'd15, -1, 8'h00, 4'd0);
        tests++;
        if (m_done_cycle != 136) begin fails++; $display("FAIL clamp_done_cycle: got %0d, want 136", m_done_cycle); end
        tests++;
        if (m_hi_min != 8 || m_hi_max != 8 || m_load != 8) begin fails++; $display("FAIL clamp_phase: got hi=%0d..%0d load=%0d, want 8", m_hi_min, m_hi_max, m_load); end
        tests++;
        if (m_dout !== 8'h81) begin fails++; $display("FAIL clamp_dout: got %h, want 81", m_dout); end
    endtask

    task automatic test_reset_mid();
        int rises, extra_done, extra_busy;
        logic prev;
        rises = 0; prev = 1'b0; extra_done = 0; extra_busy = 0;
        loop_en = 1'b1; din = 8'hE7; div = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100 && rises < 3; k++) begin
            if (k > 0) step();
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        tests++;
        if (rises != 3) begin fails++; $display("FAIL rstmid_reach: got %0d rises, want 3", rises); end
        rst = 1'b1; start = 1'b1;
        step();
        tests++;
        if ({sclk, sdo, load, busy, done} !== 5'b00000) begin fails++; $display("FAIL rstmid_outputs: got %b, want 00000", {sclk, sdo, load, busy, done}); end
        tests++;
        if (dout !== 8'h00) begin fails++; $display("FAIL rstmid_dout: got %h, want 00", dout); end
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        tests++;
        if (extra_done != 0 || extra_busy != 0 || dout !== 8'h00) begin fails++; $display("FAIL rstmid_quiet: got done=%0d busy=%0d dout=%h, want 0 0 00", extra_done, extra_busy, dout); end
        measure(8'hC3, 4'd0, -1, 8'h00, 4'd0);
        tests++;
        if (m_done_cycle != 17 || m_dout !== 8'hC3) begin fails++; $display("FAIL rstmid_recover: got done=%0d dout=%h, want 17 c3", m_done_cycle, m_dout); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; div = '0; din = '0; sdi_val = 1'b0; loop_en = 1'b1;
        test_reset();
        test_basic();
        test_div2();
        test_back_to_back();
        test_din_div_change();
        test_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shiftreg_sequencer.md
SHIFTREG_SEQUENCER -- requirements
Module: shiftreg_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: number of bits shifted per transaction.
REQ-002 SHALL have parameter DIV_WIDTH, default 4: width of the div input.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the internal half-period counter.
REQ-004 SHALL have port clk_in, input, 1 bit: reference clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port div, input, DIV_WIDTH bits: the sclk half-period is 2**div clk_in cycles.
REQ-007 SHALL have port start, input, 1 bit: transaction request, level-sampled in IDLE.
REQ-008 SHALL have port din, input, DATA_WIDTH bits: word to shift out, MSB first.
REQ-009 SHALL have port sdi, input, 1 bit: serial data from the shift-register chain.
REQ-010 SHALL have port sclk, output, 1 bit: divided serial clock, registered.
REQ-011 SHALL have port sdo, output, 1 bit: serial data to the chain, registered.
REQ-012 SHALL have port load, output, 1 bit: latch strobe to the chain, registered.
REQ-013 SHALL have port dout, output, DATA_WIDTH bits: word captured from sdi, MSB first.
REQ-014 SHALL have port busy, output, 1 bit: transaction in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-017 SHALL, in IDLE with start=1 at a clk_in edge, latch din into the shift register, latch div, clear the counter and bit index, and enter SHIFT_LO with busy=1 and sdo=din[DATA_WIDTH-1].
REQ-018 SHALL clamp a latched div value greater than CNT_WIDTH-1 to CNT_WIDTH-1.
REQ-019 SHALL give SHIFT_LO, SHIFT_HI and LOAD a duration of exactly H = 2**div_latched clk_in cycles each, timed by the half-period counter; div=0 gives H=1.
REQ-020 SHALL hold sclk=0 in SHIFT_LO and sclk=1 in SHIFT_HI.
REQ-021 SHALL, on the transition from SHIFT_LO to SHIFT_HI, shift sdi into the LSB of the capture register (capture on the sclk rising edge).
REQ-022 SHALL, on the transition from SHIFT_HI to SHIFT_LO, shift the output register left, present the next bit on sdo and increment the bit index.
REQ-023 SHALL, after the falling transition of bit DATA_WIDTH-1, enter LOAD with sclk=0, sdo=0 and load=1 for H cycles.
REQ-024 SHALL, on the exit from LOAD, enter DONE with load=0, dout=capture register, done=1 for exactly one cycle and busy still 1.
REQ-025 SHALL, on the exit from DONE, enter IDLE with busy=0.
REQ-026 SHALL place the done-asserted cycle (2*DATA_WIDTH+1)*H clk_in edges after the start-sampling edge; busy SHALL stay high for (2*DATA_WIDTH+1)*H+1 cycles.
REQ-027 SHALL ignore start in every state except IDLE; start held high continuously SHALL begin a new transaction on the first IDLE cycle after DONE.
REQ-028 SHALL ignore changes to din and div while busy=1, using only the latched values.
REQ-029 SHALL hold dout stable except on entry to DONE.

Reset
REQ-030 SHALL, when rst=1 at any clk_in edge, set the state to IDLE and set sclk, sdo, load, busy, done, dout, the counter, the bit index and the shift registers to 0.
REQ-031 SHALL, when reset occurs mid-transaction, produce no done pulse and leave dout at 0.
REQ-032 SHALL give rst priority over start when both are high at the same edge.

Verification
REQ-033 SHALL cover: DATA_WIDTH=8, div=0, din=0xA5, sdi looped to sdo, start pulse -> 8 sclk pulses of period 2, load high 1 cycle, done 17 cycles after start, dout=0xA5.
REQ-034 SHALL cover: DATA_WIDTH=8, div=2, din=0x3C, sdi tied 1 -> sclk high and low phases of 4 cycles each, load high 4 cycles, done 68 cycles after start, dout=0xFF.
REQ-035 SHALL cover: start held high continuously, div=0 -> back-to-back transactions with exactly one IDLE cycle (busy=0) between consecutive done pulses.
REQ-036 SHALL cover: rst asserted after the 3rd sclk rise -> the next cycle has sclk=sdo=load=busy=0, no done pulse and dout=0; a following start completes normally.
REQ-037 SHALL cover: div changed from 0 to 3 and din changed during SHIFT -> timing stays H=1 and the original din bits appear on sdo.
REQ-038 SHALL cover: div=15 with CNT_WIDTH=4 -> H clamped to 8 cycles.
